pipelined_decode_stage: RTL and testbench

//  Registered decode stage for the multi-register datapath computer. Accepts a raw instruction from fetch over
//  a valid/ready handshake and decodes it into datapath control words (DA/AA/BA/MB/FS/MD/RW/MW/PL/JB/BC).

---
 rtl/decode_pkg.sv | 51 +++++
 rtl/inst_field_decode.sv | 34 +++
 rtl/pipelined_decode_stage.sv | 126 ++++++++++++
 tb/tb_pipelined_decode_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode bit positions, ALU function-select codes and the
// control word carried from decode to execute.
package decode_pkg;

    localparam int OP_W       = 7;
    localparam int MAX_REG_AW = 8;

    localparam int OP_MB = 6;
    localparam int OP_F  = 5;
    localparam int OP_MD = 4;
    localparam int OP_BC = 0;

    typedef enum logic [3:0] {
        FS_MOVA   = 4'b0000,
        FS_INC    = 4'b0001,
        FS_ADD    = 4'b0010,
        FS_ADDC   = 4'b0011,
        FS_ADDNB  = 4'b0100,
        FS_SUB    = 4'b0101,
        FS_DEC    = 4'b0110,
        FS_MOVA2  = 4'b0111,
        FS_AND    = 4'b1000,
        FS_OR     = 4'b1001,
        FS_XOR    = 4'b1010,
        FS_NOT    = 4'b1011,
        FS_MOVB   = 4'b1100,
        FS_SHR    = 4'b1101,
        FS_SHL    = 4'b1110,
        FS_RSVD   = 4'b1111
    } fs_e;

    // Register fields are sized for the widest supported REG_AW and zero-extended.
    typedef struct packed {
        logic [MAX_REG_AW-1:0] da;
        logic [MAX_REG_AW-1:0] aa;
        logic [MAX_REG_AW-1:0] ba;
        logic                  mb;
        fs_e                   fs;
        logic                  md;
        logic                  rw;
        logic                  mw;
        logic                  pl;
        logic                  jb;
        logic                  bc;
    } ctrl_word_t;

    function automatic int inst_w(input int reg_aw);
        return OP_W + 3 * reg_aw;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational instruction decoder: raw {op, DA, AA, BA} word to datapath control word.
module inst_field_decode
    import decode_pkg::*;
#(
    parameter  int REG_AW = 2,
    localparam int INST_W = inst_w(REG_AW)
) (
    input  logic [INST_W-1:0] inst,
    output ctrl_word_t        cw
);

    logic [OP_W-1:0] op;
    logic            f1;

    always_comb begin
        op = inst[INST_W-1 -: OP_W];
        f1 = op[OP_MB] & op[OP_F];

        cw                   = '0;
        cw.da[REG_AW-1:0]    = inst[3*REG_AW-1 -: REG_AW];
        cw.aa[REG_AW-1:0]    = inst[2*REG_AW-1 -: REG_AW];
        cw.ba[REG_AW-1:0]    = inst[REG_AW-1:0];
        cw.mb                = op[OP_MB];
        // Branch/jump opcodes reuse op0 as the condition bit, so it is masked out of FS.
        cw.fs                = fs_e'({op[3:1], op[OP_BC] & ~f1});
        cw.md                = op[OP_MD];
        cw.rw                = ~op[OP_F];
        cw.mw                = ~op[OP_MB] & op[OP_F];
        cw.pl                = f1;
        cw.jb                = op[OP_MD];
        cw.bc                = op[OP_BC];
    end

endmodule

// File: rtl/pipelined_decode_stage.sv
// Registered decode stage: valid/ready input, one pipeline register towards execute,
// register scoreboard for RAW/WAW stalls, branch flush and a saturating stall counter.
module pipelined_decode_stage
    import decode_pkg::*;
#(
    parameter  int REG_AW = 2,
    parameter  int CNT_W  = 16,
    localparam int NREG   = 2**REG_AW,
    localparam int INST_W = inst_w(REG_AW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_da,
    output logic [REG_AW-1:0] out_aa,
    output logic [REG_AW-1:0] out_ba,
    output logic              out_mb,
    output logic              out_md,
    output logic              out_rw,
    output logic              out_mw,
    output logic              out_pl,
    output logic              out_jb,
    output logic              out_bc,
    output logic [3:0]        out_fs,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    output logic [NREG-1:0]   pending,
    output logic [CNT_W-1:0]  stall_cnt
);

    ctrl_word_t       dec_word;
    ctrl_word_t       word_q, word_d;
    logic             vld_q, vld_d;
    logic [NREG-1:0]  sb_q, sb_d;
    logic [NREG-1:0]  busy;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             accept;
    logic             transfer;

    inst_field_decode #(.REG_AW(REG_AW)) u_dec (
        .inst (in_inst),
        .cw   (dec_word)
    );

    // A register is busy if it is pending and not being written back this cycle, or if
    // the entry still held here will write it once it moves to execute.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
        logic wb_hit;
        logic held_hit;
        logic xfer_hit;

        always_comb begin
            wb_hit   = wb_valid & (wb_addr == REG_AW'(gi));
            held_hit = vld_q & word_q.rw & (word_q.da[REG_AW-1:0] == REG_AW'(gi));
            xfer_hit = transfer & word_q.rw & (word_q.da[REG_AW-1:0] == REG_AW'(gi));
            busy[gi] = (sb_q[gi] & ~wb_hit) | held_hit;
            sb_d[gi] = (sb_q[gi] & ~wb_hit) | xfer_hit;
        end
    end

    always_comb begin
        hazard    = in_valid & (busy[dec_word.aa[REG_AW-1:0]]
                              | (~dec_word.mb & busy[dec_word.ba[REG_AW-1:0]])
                              | (dec_word.rw & busy[dec_word.da[REG_AW-1:0]]));
        in_ready  = ~rst & ~flush & ~hazard & (~vld_q | out_ready);
        out_valid = vld_q & ~flush;
        accept    = in_valid & in_ready;
        transfer  = out_valid & out_ready;

        vld_d  = vld_q;
        word_d = word_q;
        if (accept) begin
            vld_d  = 1'b1;
            word_d = dec_word;
        end else if (transfer || flush) begin
            vld_d  = 1'b0;
        end

        cnt_d = cnt_q;
        if (in_valid && hazard && !flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            word_q <= '0;
            sb_q   <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            word_q <= word_d;
            sb_q   <= sb_d;
            cnt_q  <= cnt_d;
        end
    end

    if (REG_AW < MAX_REG_AW) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{word_q.da[MAX_REG_AW-1:REG_AW],
                             word_q.aa[MAX_REG_AW-1:REG_AW],
                             word_q.ba[MAX_REG_AW-1:REG_AW]};
    end

    assign out_da    = word_q.da[REG_AW-1:0];
    assign out_aa    = word_q.aa[REG_AW-1:0];
    assign out_ba    = word_q.ba[REG_AW-1:0];
    assign out_mb    = word_q.mb;
    assign out_fs    = word_q.fs;
    assign out_md    = word_q.md;
    assign out_rw    = word_q.rw;
    assign out_mw    = word_q.mw;
    assign out_pl    = word_q.pl;
    assign out_jb    = word_q.jb;
    assign out_bc    = word_q.bc;
    assign pending   = sb_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Self-checking bench for pipelined_decode_stage: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the decode stage.
module tb_pipelined_decode_stage;

    localparam int REG_AW  = 2;
    localparam int CNT_W   = 4;
    localparam int INST_W  = 13;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [INST_W-1:0] in_inst = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_da, out_aa, out_ba;
    logic              out_mb, out_md, out_rw, out_mw, out_pl, out_jb, out_bc;
    logic [3:0]        out_fs;
    logic              flush = 1'b0;
    logic              wb_valid = 1'b0;
    logic [1:0]        wb_addr = '0;
    logic [3:0]        pending;
    logic [CNT_W-1:0]  stall_cnt;
    logic [17:0]       out_bus;

    always #5 clk = ~clk;

    pipelined_decode_stage #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_da    (out_da),
        .out_aa    (out_aa),
        .out_ba    (out_ba),
        .out_mb    (out_mb),
        .out_md    (out_md),
        .out_rw    (out_rw),
        .out_mw    (out_mw),
        .out_pl    (out_pl),
        .out_jb    (out_jb),
        .out_bc    (out_bc),
        .out_fs    (out_fs),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .pending   (pending),
        .stall_cnt (stall_cnt)
    );

    assign out_bus = {out_da, out_aa, out_ba, out_mb, out_fs, out_md, out_rw, out_mw,
                      out_pl, out_jb, out_bc};

    typedef struct packed {
        bit [1:0] da;
        bit [1:0] aa;
        bit [1:0] ba;
        bit       mb;
        bit [3:0] fs;
        bit       md;
        bit       rw;
        bit       mw;
        bit       pl;
        bit       jb;
        bit       bc;
    } cw_t;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit       m_vld;
    cw_t      m_w;
    bit [3:0] m_pend;
    int       m_cnt;
    bit       e_ready, e_ovalid, e_haz;

    function automatic cw_t dec(input bit [12:0] i);
        cw_t      r;
        bit [6:0] op;
        bit       f1;
        op   = i[12:6];
        f1   = op[6] & op[5];
        r.da = i[5:4];
        r.aa = i[3:2];
        r.ba = i[1:0];
        r.mb = op[6];
        r.fs = {op[3:1], op[0] & ~f1};
        r.md = op[4];
        r.rw = ~op[5];
        r.mw = ~op[6] & op[5];
        r.pl = f1;
        r.jb = op[4];
        r.bc = op[0];
        return r;
    endfunction

    function automatic bit busy(input int r);
        return (m_pend[r] && !(wb_valid && wb_addr == r)) || (m_vld && m_w.rw && m_w.da == r);
    endfunction

    task automatic model_eval();
        cw_t d;
        d        = dec(in_inst);
        e_haz    = in_valid && (busy(d.aa) || (!d.mb && busy(d.ba)) || (d.rw && busy(d.da)));
        e_ready  = !rst && !flush && !e_haz && (!m_vld || out_ready);
        e_ovalid = m_vld && !flush;
    endtask

    // Advance the model by one clock with the inputs currently driven, then cross the edge.
    task automatic step();
        bit       xfer, acc;
        bit [3:0] np;
        model_eval();
        if (rst) begin
            m_vld  = 0;
            m_w    = '0;
            m_pend = '0;
            m_cnt  = 0;
        end else begin
            xfer = e_ovalid && out_ready;
            acc  = in_valid && e_ready;
            if (in_valid && e_haz && !flush && m_cnt < CNT_MAX) m_cnt++;
            np = m_pend;
            if (wb_valid) np[wb_addr] = 1'b0;
            if (xfer && m_w.rw) np[m_w.da] = 1'b1;
            m_pend = np;
            if (acc) begin
                $display("accept inst=%h t=%0t", in_inst, $time);
                m_w   = dec(in_inst);
                m_vld = 1;
            end else if (xfer || flush) begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 0;
        in_inst   = '0;
        out_ready = 0;
        flush     = 0;
        wb_valid  = 0;
        wb_addr   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst      = 1;
        in_valid = 1;
        in_inst  = 13'h09B;
        step();
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (pending !== 4'b0) begin failures++; $display("FAIL reset_pending got=%b want=0000", pending); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        checks++; if (out_bus !== 18'h0) begin failures++; $display("FAIL reset_fields got=%h want=0", out_bus); end
        rst = 0;
        idle_inputs();
        step();
    endtask

    task automatic test_decode();
        do_reset();
        in_valid = 1;
        in_inst  = 13'h09B;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL decode_in_ready got=%b want=1", in_ready); end
        step();
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL decode_out_valid got=%b want=1", out_valid); end
        checks++; if (out_fs !== 4'b0010) begin failures++; $display("FAIL decode_fs got=%b want=0010", out_fs); end
        checks++; if ({out_rw, out_mb} !== 2'b10) begin failures++; $display("FAIL decode_rw_mb got=%b want=10", {out_rw, out_mb}); end
        checks++; if ({out_da, out_aa, out_ba} !== 6'b01_10_11) begin failures++; $display("FAIL decode_regs got=%b want=011011", {out_da, out_aa, out_ba}); end
    endtask

    task automatic test_hazard();
        do_reset();
        in_valid = 1;
        in_inst  = 13'h09B;
        step();
        in_valid  = 0;
        out_ready = 1;
        step();
        in_inst  = 13'h0A4;
        in_valid = 1;
        @(negedge clk);
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL hazard_pending_set got=%b want=0010", pending); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hazard_stall got=%b want=0", in_ready); end
        step();
        step();
        step();
        wb_valid = 1;
        wb_addr  = 2'd1;
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL hazard_stall_cnt got=%0d want=3", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hazard_wb_release got=%b want=1", in_ready); end
        step();
        wb_valid = 0;
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);
        checks++; if (pending[1] !== 1'b0) begin failures++; $display("FAIL hazard_pending_clear got=%b want=0", pending[1]); end
        checks++; if (out_valid !== 1'b1 || out_da !== 2'd2) begin failures++; $display("FAIL hazard_accepted got=%b/%0d want=1/2", out_valid, out_da); end
        checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL hazard_cnt_hold got=%0d want=3", stall_cnt); end
    endtask

    task automatic test_immediate();
        do_reset();
        in_valid  = 1;
        in_inst   = 13'h09B;
        out_ready = 1;
        step();
        in_valid = 0;
        step();
        in_inst  = 13'h1001;
        in_valid = 1;
        @(negedge clk);
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL imm_pending got=%b want=0010", pending); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL imm_no_stall got=%b want=1", in_ready); end
        step();
        in_inst = 13'h1004;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL imm_aa_stall got=%b want=0", in_ready); end
        step();
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL imm_stall_cnt got=%0d want=1", stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        in_valid = 1;
        in_inst  = 13'h1840;
        step();
        in_valid = 0;
        @(negedge clk);
        checks++; if ({out_pl, out_rw, out_bc, out_jb} !== 4'b1010) begin failures++; $display("FAIL branch_ctrl got=%b want=1010", {out_pl, out_rw, out_bc, out_jb}); end
        checks++; if (out_fs !== 4'b0000) begin failures++; $display("FAIL branch_fs got=%b want=0000", out_fs); end
        out_ready = 1;
        step();
        @(negedge clk);
        checks++; if (pending !== 4'b0000 || out_valid !== 1'b0) begin failures++; $display("FAIL branch_no_sb got=%b/%b want=0000/0", pending, out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1;
        in_inst  = 13'h09B;
        step();
        flush     = 1;
        out_ready = 1;
        in_inst   = 13'h1840;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        step();
        flush    = 0;
        in_valid = 0;
        @(negedge clk);
        checks++; if (pending !== 4'b0000 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_killed got=%b/%b want=0000/0", pending, out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1;
        in_inst  = 13'h0A4;
        step();
        in_valid  = 0;
        out_ready = 1;
        wb_valid  = 1;
        wb_addr   = 2'd2;
        step();
        wb_valid = 0;
        @(negedge clk);
        checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL b2b_set_wins got=%b want=0100", pending); end
        do_reset();
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1;
            in_inst  = 13'h1840 | 13'(k);
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b want=1", k, in_ready); end
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_ba !== 2'(k - 1)) begin
                    failures++; $display("FAIL b2b_stream[%0d] got=%b/%0d want=1/%0d", k, out_valid, out_ba, k - 1);
                end
            end
            step();
        end
        rst = 1;
        step();
        @(negedge clk);
        checks++; if ({out_valid, in_ready, pending} !== 6'b0 || out_bus !== 18'h0) begin failures++; $display("FAIL b2b_midreset got=%b/%h want=0/0", {out_valid, in_ready, pending}, out_bus); end
        rst = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid  = 1;
        in_inst   = 13'h09B;
        out_ready = 1;
        step();
        in_valid = 0;
        step();
        in_valid = 1;
        in_inst  = 13'h0A4;
        for (int k = 0; k < 20; k++) step();
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall_cnt got=%0d want=15", stall_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = 13'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            wb_valid  = ($urandom_range(0, 1) == 1);
            wb_addr   = 2'($urandom);
            @(negedge clk);
            model_eval();
            checks++; if (in_ready !== e_ready) begin failures++; $display("FAIL rand_in_ready[%0d] got=%b want=%b", n, in_ready, e_ready); end
            checks++; if (out_valid !== e_ovalid) begin failures++; $display("FAIL rand_out_valid[%0d] got=%b want=%b", n, out_valid, e_ovalid); end
            checks++; if (out_bus !== 18'(m_w)) begin failures++; $display("FAIL rand_fields[%0d] got=%h want=%h", n, out_bus, 18'(m_w)); end
            checks++; if (pending !== m_pend) begin failures++; $display("FAIL rand_pending[%0d] got=%b want=%b", n, pending, m_pend); end
            checks++; if (stall_cnt !== 4'(m_cnt)) begin failures++; $display("FAIL rand_stall_cnt[%0d] got=%0d want=%0d", n, stall_cnt, m_cnt); end
            step();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_hazard();
        test_immediate();
        test_branch();
        test_flush();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
